// File: rtl/pspi_tx_scheduler.sv
// PSPI master transmit scheduler: round-robin requester arbitration, frame
// launch on the SCLK generator, NACK retry sequencing and per-attempt watchdog.
module pspi_tx_scheduler #(
    parameter int NREQ      = 2,
    parameter int DATA_W    = 8,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 600_000_000,
    parameter int TO_W      = 30
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        fail,
    output logic                   run,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   tx_parity,
    input  logic                   select,
    input  logic                   nack,
    output logic                   busy,
    output logic [2:0]             attempt,
    output logic                   timeout_err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LAUNCH     = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_WAIT_END   = 3'd3;
    localparam logic [2:0] S_EVAL       = 3'd4;
    localparam logic [2:0] S_TO_EXIT    = 3'd5;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_sel;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_sel_inc;
    logic              w_found;
    logic [DATA_W-1:0] w_slice;
    logic              w_to;
    logic              w_retry;
    logic [NREQ-1:0]   w_sel_oh;
    logic [TO_W-1:0]   r_cnt;
    logic              r_nack_seen;
    logic [2:0]        r_attempt;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   r_fail;
    logic              r_run;
    logic              r_busy;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_parity;
    logic              r_timeout_err;

    // First set request at or above the pointer, wrapping to index 0.
    always_comb begin
        logic [PW:0] w_idx;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NREQ))
                w_idx = w_idx - (PW+1)'(NREQ);
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_slice = '0;
        for (int unsigned k = 0; k < NREQ; k++)
            if (w_win == PW'(k))
                w_slice = req_data[k*DATA_W +: DATA_W];
    end

    assign w_to      = (r_cnt == TO_LAST);
    assign w_retry   = r_nack_seen && (r_attempt < 3'(MAX_RETRY));
    assign w_sel_oh  = NREQ'(1) << r_sel;
    assign w_sel_inc = (r_sel == PW'(NREQ - 1)) ? '0 : r_sel + PW'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_found) w_next = S_LAUNCH;
            S_LAUNCH:     w_next = S_WAIT_START;
            S_WAIT_START: if (!select) w_next = S_WAIT_END;
                          else if (w_to) w_next = S_TO_EXIT;
            S_WAIT_END:   if (select) w_next = S_EVAL;
                          else if (w_to) w_next = S_TO_EXIT;
            S_EVAL:       w_next = w_retry ? S_LAUNCH : S_IDLE;
            S_TO_EXIT:    w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_sel         <= '0;
            r_cnt         <= '0;
            r_nack_seen   <= 1'b0;
            r_attempt     <= '0;
            r_grant       <= '0;
            r_done        <= '0;
            r_fail        <= '0;
            r_run         <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_data     <= '0;
            r_tx_parity   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_run   <= (r_state == S_LAUNCH);
            r_grant <= '0;
            r_done  <= '0;
            r_fail  <= '0;
            case (r_state)
                S_IDLE: if (w_found) begin
                    r_sel         <= w_win;
                    r_grant       <= NREQ'(1) << w_win;
                    r_tx_data     <= w_slice;
                    r_tx_parity   <= ^w_slice;
                    r_attempt     <= '0;
                    r_timeout_err <= 1'b0;
                end
                S_LAUNCH: begin
                    r_cnt       <= '0;
                    r_nack_seen <= 1'b0;
                end
                S_WAIT_START: if (!w_to) r_cnt <= r_cnt + TO_W'(1);
                S_WAIT_END: begin
                    if (!w_to) r_cnt <= r_cnt + TO_W'(1);
                    r_nack_seen <= r_nack_seen | nack;
                end
                S_EVAL: begin
                    if (!r_nack_seen) begin
                        r_done <= w_sel_oh;
                        r_ptr  <= w_sel_inc;
                    end else if (w_retry) begin
                        r_attempt <= r_attempt + 3'd1;
                    end else begin
                        r_fail <= w_sel_oh;
                        r_ptr  <= w_sel_inc;
                    end
                end
                S_TO_EXIT: begin
                    r_fail        <= w_sel_oh;
                    r_timeout_err <= 1'b1;
                    r_ptr         <= w_sel_inc;
                end
                default: ;
            endcase
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign fail        = r_fail;
    assign run         = r_run;
    assign tx_data     = r_tx_data;
    assign tx_parity   = r_tx_parity;
    assign busy        = r_busy;
    assign attempt     = r_attempt;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pspi_tx_scheduler.sv
// Bench for pspi_tx_scheduler: a transaction-level schedule of stimulus and
// expected per-cycle outputs is built first, then replayed and compared.
module tb_pspi_tx_scheduler;
    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int MAXR = 3;
    localparam int TO   = 50;
    localparam int N    = 6000;

    logic clk;
    logic rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] grant, done, fail;
    logic run, tx_parity, select, nack, busy, timeout_err;
    logic [DW-1:0] tx_data;
    logic [2:0] attempt;

    pspi_tx_scheduler #(.NREQ(NREQ), .DATA_W(DW), .MAX_RETRY(MAXR),
                        .TIMEOUT(TO), .TO_W(30)) u_dut (
        .clk_in(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .fail(fail), .run(run),
        .tx_data(tx_data), .tx_parity(tx_parity), .select(select),
        .nack(nack), .busy(busy), .attempt(attempt), .timeout_err(timeout_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus schedule, indexed by cycle
    logic [NREQ-1:0]    s_req  [N];
    logic [NREQ*DW-1:0] s_data [N];
    logic               s_sel  [N];
    logic               s_nack [N];
    logic               s_rst  [N];
    // expected outputs per cycle
    logic [NREQ-1:0] e_grant [N];
    logic [NREQ-1:0] e_done  [N];
    logic [NREQ-1:0] e_fail  [N];
    logic            e_run   [N];
    logic            e_busy  [N];
    logic            e_par   [N];
    logic            e_toerr [N];
    logic [DW-1:0]   e_txd   [N];
    logic [2:0]      e_att   [N];
    // held-value change events, expanded into e_* by a forward pass
    bit            txd_s [N];
    logic [DW-1:0] txd_v [N];
    bit            att_s [N];
    logic [2:0]    att_v [N];
    bit            toe_s [N];
    bit            toe_v [N];
    bit            bsy_s [N];
    bit            bsy_v [N];

    int checks = 0;
    int failures = 0;
    int t, tend, ptr, cr_rec;
    int fs [8];
    int fe [8];
    logic [NREQ-1:0] pend;
    logic [DW-1:0]   dat [NREQ];

    task automatic chk(input string nm, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, c, act, exp);
        end
    endtask

    task automatic fill(input int c, input bit noise);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
                s_req[c][i] = 1'b1;
                s_data[c][i*DW +: DW] = dat[i];
            end else begin
                s_req[c][i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                s_data[c][i*DW +: DW] = DW'($urandom);
            end
        end
    endtask

    task automatic arrive(input int pct);
        for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 99) < pct) begin
                pend[i] = 1'b1;
                dat[i]  = DW'($urandom);
            end
    endtask

    function automatic int arb();
        for (int k = 0; k < NREQ; k++)
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic int runs_in(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) n += int'(e_run[c]);
        return n;
    endfunction

    // mode: 0 random, 1 plain ACK of 0xA5, 2 always NACK, 3 NACK twice then
    // ACK, 4 watchdog, 5 reset inside WAIT_END, 6 both requesters held
    task automatic frame(input int mode, input int rec);
        int t0, w, R, a, d1, d2, H, E, cr;
        bit nk, tmo, ab;
        logic [NREQ-1:0] oh;
        case (mode)
            1: begin pend = 2'b01; dat[0] = 8'hA5; end
            2: begin pend = 2'b01; dat[0] = 8'h07; end
            3, 4: begin pend = 2'b01; dat[0] = DW'($urandom); end
            5: begin pend = 2'b10; dat[1] = DW'($urandom); end
            6: arrive(100);
            default: begin
                arrive(50);
                while (pend == '0) begin
                    fill(t, 1'b0);
                    t++;
                    arrive(50);
                end
            end
        endcase
        t0 = t;
        fill(t0, 1'b0);
        w = arb();
        pend[w] = 1'b0;
        oh = NREQ'(1) << w;
        e_grant[t0+1] = oh;
        txd_s[t0+1] = 1; txd_v[t0+1] = dat[w];
        att_s[t0+1] = 1; att_v[t0+1] = 3'd0;
        toe_s[t0+1] = 1; toe_v[t0+1] = 0;
        bsy_s[t0+1] = 1; bsy_v[t0+1] = 1;
        R = t0 + 2; a = 0; ab = 0; E = 0;
        forever begin
            e_run[R] = 1'b1;
            tmo = (mode == 4) || (mode == 0 && $urandom_range(0, 9) == 0);
            d1  = (mode == 1) ? 18 : int'($urandom_range(0, 5));
            d2  = (mode == 1) ? 25 : int'($urandom_range(2, 8));
            nk  = (mode == 2) ? 1'b1 : (mode == 3) ? (a < 2) :
                  (mode == 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
            H   = R + d1 + d2;
            if (tmo) begin
                if (mode == 0) s_nack[R + int'($urandom_range(0, TO-1))] = 1'b1;
                E = R + TO + 1;
                e_fail[E] = oh;
                toe_s[E] = 1; toe_v[E] = 1;
                break;
            end
            if (mode == 5) begin
                cr = R + d1 + 1 + int'($urandom_range(0, d2-2));
                for (int k = R + d1; k <= cr; k++) s_sel[k] = 1'b0;
                for (int k = cr; k <= cr + 2; k++) s_rst[k] = 1'b0;
                ab = 1; E = cr + 3; cr_rec = cr;
                break;
            end
            for (int k = R + d1; k < H; k++) s_sel[k] = 1'b0;
            if (nk) s_nack[R + d1 + 1 + int'($urandom_range(0, d2-1))] = 1'b1;
            if (mode == 0 && $urandom_range(0, 1) == 1) s_nack[R + d1] = 1'b1;
            if (mode == 0 && $urandom_range(0, 1) == 1) s_nack[H + 1] = 1'b1;
            if (nk && a < MAXR) begin
                a++;
                att_s[H+2] = 1; att_v[H+2] = 3'(a);
                R = H + 3;
            end else begin
                E = H + 2;
                if (nk) e_fail[E] = oh;
                else e_done[E] = oh;
                break;
            end
        end
        bsy_s[E] = 1; bsy_v[E] = 0;
        for (int k = t0 + 1; k < E; k++) fill(k, 1'b1);
        if (ab) begin
            ptr = 0;
            pend = '1;
            for (int i = 0; i < NREQ; i++) dat[i] = DW'($urandom);
        end else begin
            ptr = (w + 1) % NREQ;
        end
        t = E;
        fs[rec] = t0;
        fe[rec] = E;
    endtask

    initial begin
        logic [DW-1:0] ctx;
        logic [2:0] cat;
        bit cto, cb, zero;
        rst_n = 1'b0; req = '0; req_data = '0; select = 1'b1; nack = 1'b0;
        for (int c = 0; c < N; c++) begin
            s_req[c] = '0; s_data[c] = '0; s_sel[c] = 1'b1; s_nack[c] = 1'b0; s_rst[c] = 1'b1;
            e_grant[c] = '0; e_done[c] = '0; e_fail[c] = '0; e_run[c] = 1'b0;
            txd_s[c] = 0; att_s[c] = 0; toe_s[c] = 0; bsy_s[c] = 0;
            txd_v[c] = '0; att_v[c] = '0; toe_v[c] = 0; bsy_v[c] = 0;
        end
        for (int c = 0; c < 4; c++) s_rst[c] = 1'b0;
        t = 4; ptr = 0; pend = '0; cr_rec = 0;
        for (int i = 0; i < NREQ; i++) dat[i] = '0;

        frame(1, 0);
        frame(2, 1);
        frame(3, 2);
        frame(4, 3);
        frame(5, 4);
        frame(0, 5);
        for (int k = 0; k < 4; k++) frame(6, 6);
        while (t < N - 400) frame(0, 7);
        tend = t;
        pend = '0;
        for (int c = tend; c <= tend + 4; c++) fill(c, 1'b0);

        ctx = '0; cat = '0; cto = 0; cb = 0;
        for (int c = 0; c <= tend + 4; c++) begin
            zero = (c == 0) ? 1'b1 : !s_rst[c-1];
            if (zero) begin
                ctx = '0; cat = '0; cto = 0; cb = 0;
                e_grant[c] = '0; e_done[c] = '0; e_fail[c] = '0; e_run[c] = 1'b0;
            end else begin
                if (txd_s[c]) ctx = txd_v[c];
                if (att_s[c]) cat = att_v[c];
                if (toe_s[c]) cto = toe_v[c];
                if (bsy_s[c]) cb = bsy_v[c];
            end
            e_txd[c] = ctx; e_par[c] = ^ctx; e_att[c] = cat;
            e_toerr[c] = cto; e_busy[c] = cb;
        end

        // hand-derived anchors for the directed frames
        chk("pin_grant_first", 5, int'(e_grant[5]), 1);
        chk("pin_run_first", 6, int'(e_run[6]), 1);
        chk("pin_txd_first", 5, int'(e_txd[5]), 'hA5);
        chk("pin_par_first", 5, int'(e_par[5]), 0);
        chk("pin_done_first", 51, int'(e_done[51]), 1);
        chk("pin_busy_first", 51, int'(e_busy[51]), 0);
        chk("pin_runs_exhaust", fe[1], runs_in(fs[1], fe[1]), 4);
        chk("pin_fail_exhaust", fe[1], int'(e_fail[fe[1]]), 1);
        chk("pin_par_exhaust", fe[1], int'(e_par[fe[1]]), 1);
        chk("pin_att_exhaust", fe[1], int'(e_att[fe[1]]), 3);
        chk("pin_runs_retry", fe[2], runs_in(fs[2], fe[2]), 3);
        chk("pin_done_retry", fe[2], int'(e_done[fe[2]]), 1);
        chk("pin_att_retry", fe[2], int'(e_att[fe[2]]), 2);
        chk("pin_fail_timeout", fs[3] + 53, int'(e_fail[fs[3] + 53]), 1);
        chk("pin_toerr_set", fs[3] + 53, int'(e_toerr[fs[3] + 53]), 1);
        chk("pin_toerr_clear", fs[4] + 1, int'(e_toerr[fs[4] + 1]), 0);
        chk("pin_grant_after_rst", cr_rec + 4, int'(e_grant[cr_rec + 4]), 1);

        for (int c = 0; c <= tend + 4; c++) begin
            @(negedge clk);
            chk("grant", c, int'(grant), int'(e_grant[c]));
            chk("done", c, int'(done), int'(e_done[c]));
            chk("fail", c, int'(fail), int'(e_fail[c]));
            chk("run", c, int'(run), int'(e_run[c]));
            chk("busy", c, int'(busy), int'(e_busy[c]));
            chk("tx_data", c, int'(tx_data), int'(e_txd[c]));
            chk("tx_parity", c, int'(tx_parity), int'(e_par[c]));
            chk("attempt", c, int'(attempt), int'(e_att[c]));
            chk("timeout_err", c, int'(timeout_err), int'(e_toerr[c]));
            rst_n    = s_rst[c];
            req      = s_req[c];
            req_data = s_data[c];
            select   = s_sel[c];
            nack     = s_nack[c];
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pspi_tx_scheduler.md
Name: pspi_tx_scheduler

Overview:
- Transmission controller for the PSPI master.
- Arbitrates round-robin between NREQ byte requesters and latches the winner's byte with its even-parity bit.
- Launches each frame on the SCLK clock generator with a one-cycle run pulse and tracks the frame via the generator's select output.
- Sequences retries on slave NACK (parity error), with a bounded retry count and a per-frame watchdog timeout; the generator's own retry input is tied low at top level.

Parameters:
NREQ, 2, number of requesters (2..8)
DATA_W, 8, payload bits per frame
MAX_RETRY, 3, retries after first attempt (total attempts = MAX_RETRY+1)
TIMEOUT, 600_000_000, clk_in cycles allowed per attempt in WAIT_START+WAIT_END
TO_W, 30, timeout counter width

Ports:
clk_in  in  1  system clock (100 MHz board clock)
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester transmit request, level, held until grant
req_data  in  NREQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
grant  out  NREQ  one-hot, 1-cycle pulse: request accepted, data latched
done  out  NREQ  1-cycle pulse: frame acknowledged (no NACK)
fail  out  NREQ  1-cycle pulse: retries exhausted or timeout
run  out  1  1-cycle pulse to clock generator starting an attempt
tx_data  out  DATA_W  latched payload for the shift stage
tx_parity  out  1  even parity bit: XOR of tx_data
select  in  1  from clock generator: low while frame in flight, high idle
nack  in  1  slave parity-error indication
busy  out  1  high whenever state != IDLE
attempt  out  3  current attempt index, 0 = first transmission
timeout_err  out  1  sticky; set on watchdog expiry, cleared on next grant

Behaviour:
- Reset (async, rst_n=0) state and outputs: state IDLE, RR pointer 0, attempt 0, timeout counter 0, nack_seen 0, timeout_err 0, tx_data 0, tx_parity 0. All pulse outputs 0 and busy 0. Reset mid-frame aborts silently: no done/fail pulse.
- All outputs are registered.
- IDLE:
  - If any req bit is set, pick the first set bit scanning from pointer upward with wrap. Selection is combinational in this cycle.
  - Next cycle: grant[i]=1, tx_data=req_data slice i, tx_parity=^slice, attempt=0, timeout_err=0; go LAUNCH.
  - If no req, stay in IDLE.
- LAUNCH: run=1 for exactly this cycle. Clear the timeout counter and nack_seen. Go WAIT_START.
- WAIT_START:
  - select==0 -> WAIT_END.
  - Counter reaches TIMEOUT-1 -> TIMEOUT_EXIT.
- WAIT_END:
  - nack_seen |= nack every cycle.
  - select==1 -> EVAL; nack is also OR'd in on this cycle.
  - Counter reaches TIMEOUT-1 -> TIMEOUT_EXIT.
- EVAL (one cycle):
  - nack_seen==0 -> done[i] pulse next cycle, pointer=(i+1) mod NREQ, go IDLE.
  - nack_seen==1 and attempt<MAX_RETRY -> attempt+1, go LAUNCH; tx_data and tx_parity unchanged.
  - nack_seen==1 and attempt==MAX_RETRY -> fail[i] pulse, pointer=(i+1) mod NREQ, go IDLE.
- TIMEOUT_EXIT: fail[i] pulse, timeout_err=1, pointer advances, go IDLE. No retry after a timeout.
- Latency:
  - req to grant: 1 cycle from IDLE.
  - grant to run: 1 cycle.
  - select rise to done/fail: 2 cycles.
- Arbitration boundaries:
  - A req that drops after grant is ignored; the latched data is used.
  - req changes during a frame are not sampled.
  - A requester holding req after done is re-granted only after the other pending requesters (pointer already advanced).
  - Simultaneous requests: lowest index at or above pointer wins.
- nack outside WAIT_END is ignored. A glitch-high select in WAIT_START (frame not yet started) keeps the state machine waiting.
- The pointer wraps from NREQ-1 to 0.
- The timeout counter saturates; it never wraps within an attempt.

Test Plan:
- Reset then req=01, req_data[7:0]=0xA5, select low 20 cycles later, high 100 cycles after, nack=0 -> grant=01 at +1, run at +2, tx_parity=0, done=01 two cycles after select rise, busy low after.
- req=11 held continuously, each frame ACKed -> grants alternate 01,10,01,10; no requester granted twice in a row.
- req[0] data 0x07, nack=1 pulsed in every WAIT_END, MAX_RETRY=3 -> exactly 4 run pulses, attempt 0..3, tx_parity=1 throughout, fail=01 once, no done.
- nack=1 on attempts 0 and 1, nack=0 on attempt 2 -> 3 run pulses, done=01, attempt=2 at completion.
- TIMEOUT=50 override, select never falls after run -> fail pulse at run+51 ±1, timeout_err=1, state IDLE; the next grant clears timeout_err.
- rst_n asserted in WAIT_END -> busy, run, grant, done, fail all 0 immediately; after release pointer=0 and a new req is granted normally.
